// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, constants and the byte-lane merge helper used by
//               the MEM-stage data memory controller and its storage array.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Controller states: waiting for work, counting down latency, responding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Default build geometry
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_LATENCY = 2;
  localparam int NB          = DEF_DATA_W / 8;
  localparam int CNT_W       = $clog2(DEF_LATENCY + 1);

  // Widest word the merge helper handles; callers zero-extend and truncate
  localparam int MAX_W  = 64;
  localparam int MAX_NB = MAX_W / 8;

  // Lane k takes the new byte when be[k] is set, otherwise keeps the old byte
  function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0]  old_word,
                                                input logic [MAX_W-1:0]  wdata,
                                                input logic [MAX_NB-1:0] be);
    logic [MAX_W-1:0] res;
    for (int k = 0; k < MAX_NB; k++) begin
      res[8*k +: 8] = be[k] ? wdata[8*k +: 8] : old_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Word-addressed storage with byte-lane write enables and a
//               registered read port. One access per enabled edge; a write
//               returns the merged word. No reset: contents survive rst_n.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 10,
  parameter int PRESET = 1
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Power-up image: words 500..509 hold 1..10 when PRESET is set
  function automatic mem_t preset_image();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = 'x;
    end
    if (PRESET == 1) begin
      for (int i = 0; i < 10; i++) begin
        if (500 + i < DEPTH) begin
          m[500 + i] = DATA_W'(i + 1);
        end
      end
    end
    return m;
  endfunction

  mem_t              mem_q = preset_image();
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merged;

  // With be = 0 the merge returns the old word, so the array is untouched
  assign merged = DATA_W'(be_merge(MAX_W'(mem_q[addr_i]), MAX_W'(wdata_i), MAX_NB'(be_i)));

  // Commit the access: optional lane-merged write, read port sees post-write value
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= merged;
      end
      rdata_q <= we_i ? merged : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : MEM-stage data memory with valid/ready request handshake,
//               configurable access latency, byte-lane writes and a one-cycle
//               response pulse. One request outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = DEF_LATENCY,
  parameter int PRESET  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                busy_o
);

  localparam int LANES    = DATA_W / 8;
  localparam int CNT_BITS = $clog2(LATENCY + 1);

  state_e              state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic                busy_q;
  logic                has_rsp_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LANES-1:0]    be_q;

  logic                accept;
  logic                commit;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_wdata;
  logic [LANES-1:0]    arr_be;
  logic [DATA_W-1:0]   arr_rdata;

  // req_ready_q reads 1 while in reset; gating with rst_n keeps a request
  // presented during reset from committing straight into the array
  assign accept = req_valid_i && req_ready_q && rst_n;

  // Single-cycle builds commit on the acceptance edge from the live request;
  // longer builds commit from the latched request on the last WAIT edge
  generate
    if (LATENCY == 1) begin : g_lat1
      assign commit    = accept;
      assign arr_we    = req_write_i;
      assign arr_addr  = req_addr_i;
      assign arr_wdata = req_wdata_i;
      assign arr_be    = req_be_i;
    end else begin : g_latn
      assign commit    = (state_q == WAIT) && (cnt_q == CNT_BITS'(1));
      assign arr_we    = write_q;
      assign arr_addr  = addr_q;
      assign arr_wdata = wdata_q;
      assign arr_be    = be_q;
    end
  endgenerate

  // Request FSM with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      has_rsp_q   <= 1'b0;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            if (LATENCY == 1) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              has_rsp_q   <= 1'b1;
            end else begin
              state_q     <= WAIT;
              cnt_q       <= CNT_BITS'(LATENCY - 1);
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end else begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == CNT_BITS'(1)) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            has_rsp_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_BITS'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .PRESET (PRESET)
  ) u_array (
    .clk     (clk),
    .en_i    (commit),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (arr_wdata),
    .be_i    (arr_be),
    .rdata_o (arr_rdata)
  );

  // Array read register has no reset; present zero until a response completes
  assign rsp_rdata_o = has_rsp_q ? arr_rdata : '0;
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Directed self-checking bench for dmem_ctrl. Main instance at
//               LATENCY=2, plus LATENCY=1 and LATENCY=5 instances sharing the
//               same request inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  logic        rdy2, vld2, busy2;
  logic [15:0] rd2;
  logic        rdy1, vld1, busy1;
  logic [15:0] rd1;
  logic        rdy5, vld5, busy5;
  logic [15:0] rd5;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_ctrl #(.DATA_W(16), .ADDR_W(10), .LATENCY(2), .PRESET(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy2),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(vld2), .rsp_rdata_o(rd2), .busy_o(busy2)
  );

  dmem_ctrl #(.DATA_W(16), .ADDR_W(10), .LATENCY(1), .PRESET(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(vld1), .rsp_rdata_o(rd1), .busy_o(busy1)
  );

  dmem_ctrl #(.DATA_W(16), .ADDR_W(10), .LATENCY(5), .PRESET(1)) u_dut_l5 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy5),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_be_i(req_be), .rsp_valid_o(vld5), .rsp_rdata_o(rd5), .busy_o(busy5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full single transaction on the LATENCY=2 instance, starting from a ready cycle
  task automatic txn(input logic w, input logic [9:0] a, input logic [15:0] d,
                     input logic [1:0] be, input logic [15:0] exp, input string tag);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    step();
    req_valid = 1'b0;
    chk({tag, " busy"}, busy2, 1);
    step();
    chk({tag, " rsp_valid"}, vld2, 1);
    chk({tag, " rdata"}, rd2, exp);
    step();
  endtask

  initial begin
    int v1_cyc, v2_cyc, v5_cyc, b1_cnt, b2_cnt, b5_cnt, pulses;
    logic [15:0] d1, d2, d5;

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset ready", rdy2, 1);
    chk("reset rsp_valid", vld2, 0);
    chk("reset rdata", rd2, 16'h0000);
    chk("reset busy", busy2, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Latency sweep: read 509 accepted by all three instances in the same cycle
    v1_cyc = 0; v2_cyc = 0; v5_cyc = 0; b1_cnt = 0; b2_cnt = 0; b5_cnt = 0;
    d1 = '0; d2 = '0; d5 = '0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd509;
    for (int c = 1; c <= 6; c++) begin
      step();
      req_valid = 1'b0;
      if (vld1) begin v1_cyc = c; d1 = rd1; end
      if (vld2) begin v2_cyc = c; d2 = rd2; end
      if (vld5) begin v5_cyc = c; d5 = rd5; end
      b1_cnt += int'(busy1);
      b2_cnt += int'(busy2);
      b5_cnt += int'(busy5);
    end
    chk("lat1 rsp cycle", v1_cyc, 1);
    chk("lat1 rdata", d1, 16'h000A);
    chk("lat1 busy cycles", b1_cnt, 0);
    chk("lat2 rsp cycle", v2_cyc, 2);
    chk("lat2 rdata", d2, 16'h000A);
    chk("lat2 busy cycles", b2_cnt, 1);
    chk("lat5 rsp cycle", v5_cyc, 5);
    chk("lat5 rdata", d5, 16'h000A);
    chk("lat5 busy cycles", b5_cnt, 4);

    // Read 500: ready drops, pulse two cycles after acceptance, then idle
    chk("rd500 ready at T", rdy2, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd500;
    step();
    req_valid = 1'b0;
    chk("rd500 ready T+1", rdy2, 0);
    chk("rd500 busy T+1", busy2, 1);
    chk("rd500 valid T+1", vld2, 0);
    step();
    chk("rd500 valid T+2", vld2, 1);
    chk("rd500 rdata T+2", rd2, 16'h0001);
    chk("rd500 ready T+2", rdy2, 1);
    chk("rd500 busy T+2", busy2, 0);
    step();
    chk("rd500 valid T+3", vld2, 0);
    chk("rd500 rdata hold", rd2, 16'h0001);
    chk("rd500 ready T+3", rdy2, 1);

    // Write 600 then back-to-back read issued in the RESP cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd600; req_wdata = 16'hBEEF; req_be = 2'b11;
    step();
    req_valid = 1'b0;
    step();
    chk("wr600 valid", vld2, 1);
    chk("wr600 rdata", rd2, 16'hBEEF);
    chk("wr600 ready in RESP", rdy2, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd600;
    step();
    req_valid = 1'b0;
    chk("b2b valid gap", vld2, 0);
    chk("b2b ready gap", rdy2, 0);
    step();
    chk("b2b rd600 valid", vld2, 1);
    chk("b2b rd600 rdata", rd2, 16'hBEEF);
    step();

    // Byte-lane writes
    txn(1'b1, 10'd600, 16'h1234, 2'b01, 16'hBE34, "wr600 be01");
    txn(1'b1, 10'd600, 16'hFFFF, 2'b00, 16'hBE34, "wr600 be00");
    txn(1'b0, 10'd600, 16'h0000, 2'b00, 16'hBE34, "rd600 after be00");

    // Reset while a write is in WAIT
    txn(1'b1, 10'd700, 16'hAAAA, 2'b11, 16'hAAAA, "wr700 init");
    req_valid = 1'b1; req_write = 1'b1; req_addr = 10'd700; req_wdata = 16'h5555; req_be = 2'b11;
    step();
    req_valid = 1'b0;
    chk("wr700 in WAIT", busy2, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset ready", rdy2, 1);
    chk("midreset rsp_valid", vld2, 0);
    chk("midreset rdata", rd2, 16'h0000);
    chk("midreset busy", busy2, 0);
    step(); step();
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      pulses += int'(vld2);
      step();
    end
    chk("midreset no pulse", pulses, 0);
    txn(1'b0, 10'd700, 16'h0000, 2'b00, 16'hAAAA, "rd700 after reset");
    txn(1'b0, 10'd500, 16'h0000, 2'b00, 16'h0001, "rd500 after reset");

    // req_valid held high; odd cycles carry a write to 509 that must be ignored
    for (int c = 0; c <= 9; c++) begin
      chk($sformatf("stream ready c%0d", c), rdy2, ((c % 2) == 0) || (c == 9));
      chk($sformatf("stream valid c%0d", c), vld2, (c >= 2) && (c <= 8) && ((c % 2) == 0));
      if ((c >= 2) && (c <= 8) && ((c % 2) == 0)) begin
        chk($sformatf("stream rdata c%0d", c), rd2, ((((c - 2) / 2) % 2) == 0) ? 16'h0002 : 16'h0003);
      end
      if (c < 8) begin
        req_valid = 1'b1;
        if ((c % 2) == 0) begin
          req_write = 1'b0;
          req_addr  = (((c / 2) % 2) == 0) ? 10'd501 : 10'd502;
        end else begin
          req_write = 1'b1; req_addr = 10'd509; req_wdata = 16'hFFFF; req_be = 2'b11;
        end
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    txn(1'b0, 10'd509, 16'h0000, 2'b00, 16'h000A, "rd509 untouched");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
